// File: rtl/sgde_scene_sequencer_if.sv
// Bundle between the scene sequencer, its scene ROM, the display engine and the frame requester.
// master is the sequencer's view; slave is the surrounding system's view.
interface sgde_scene_sequencer_if #(
  parameter int SL_AW = 5
);
  logic             go;
  logic [SL_AW-1:0] scn_cnt;
  logic             SL_CEN;
  logic [SL_AW-1:0] SL_A;
  logic [13:0]      SL_Q;
  logic             eng_rst;
  logic             eng_sprite;
  logic [1:0]       eng_type;
  logic [5:0]       eng_X;
  logic [5:0]       eng_Y;
  logic             eng_start;
  logic             eng_done;
  logic             busy;
  logic             frame_done;
  logic             err;

  modport master (
    input  go, scn_cnt, SL_Q, eng_done,
    output SL_CEN, SL_A, eng_rst, eng_sprite, eng_type, eng_X, eng_Y,
           eng_start, busy, frame_done, err
  );

  modport slave (
    output go, scn_cnt, SL_Q, eng_done,
    input  SL_CEN, SL_A, eng_rst, eng_sprite, eng_type, eng_X, eng_Y,
           eng_start, busy, frame_done, err
  );
endinterface

// File: rtl/sgde_scene_sequencer.sv
// Frame controller for the sprite display engine: resets the engine, streams the scene list
// from a synchronous ROM, validates it, starts the engine and guards completion with a watchdog.
module sgde_scene_sequencer #(
  parameter int SL_AW   = 5,
  parameter int MAX_OTH = 19,
  parameter int TIMEOUT = 8192
) (
  input logic                    clk,
  input logic                    reset,
  sgde_scene_sequencer_if.master bus
);

  localparam int               WD_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [SL_AW-1:0] MAX_LEN = SL_AW'(MAX_OTH + 1);
  localparam logic [4:0]       OTH_LIM = 5'(MAX_OTH);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ERST   = 3'd1,
    STREAM = 3'd2,
    CHECK  = 3'd3,
    START  = 3'd4,
    RUN    = 3'd5,
    FIN    = 3'd6
  } state_t;

  state_t           state_r;
  logic [SL_AW-1:0] len_r;
  logic [SL_AW-1:0] c_r;
  logic             erst_cnt_r;
  logic [4:0]       man_cnt_r;
  logic [4:0]       oth_cnt_r;
  logic [WD_W-1:0]  wd_r;

  logic             sl_cen_r;
  logic [SL_AW-1:0] sl_a_r;
  logic             eng_rst_r;
  logic             eng_sprite_r;
  logic [1:0]       eng_type_r;
  logic [5:0]       eng_x_r;
  logic [5:0]       eng_y_r;
  logic             eng_start_r;
  logic             busy_r;
  logic             frame_done_r;
  logic             err_r;

  logic             len_ok_s;
  logic             strobe_s;
  logic             scene_bad_s;
  logic [SL_AW-1:0] c_next_s;
  logic [1:0]       q_type_s;

  function automatic logic [4:0] sat_inc5(input logic [4:0] v);
    return (v == 5'd31) ? v : v + 5'd1;
  endfunction

  assign len_ok_s    = (bus.scn_cnt != {SL_AW{1'b0}}) && (bus.scn_cnt <= MAX_LEN);
  assign c_next_s    = c_r + SL_AW'(1'b1);
  // ROM data for address c-1 is on SL_Q while 1 <= c <= len
  assign strobe_s    = (c_r != {SL_AW{1'b0}}) && (c_r <= len_r);
  assign scene_bad_s = (man_cnt_r != 5'd1) || (oth_cnt_r > OTH_LIM);
  assign q_type_s    = bus.SL_Q[13:12];

  assign bus.SL_CEN     = sl_cen_r;
  assign bus.SL_A       = sl_a_r;
  assign bus.eng_rst    = eng_rst_r;
  assign bus.eng_sprite = eng_sprite_r;
  assign bus.eng_type   = eng_type_r;
  assign bus.eng_X      = eng_x_r;
  assign bus.eng_Y      = eng_y_r;
  assign bus.eng_start  = eng_start_r;
  assign bus.busy       = busy_r;
  assign bus.frame_done = frame_done_r;
  assign bus.err        = err_r;

  // Frame sequencing FSM; every output is a register updated here
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      len_r        <= {SL_AW{1'b0}};
      c_r          <= {SL_AW{1'b0}};
      erst_cnt_r   <= 1'b0;
      man_cnt_r    <= 5'd0;
      oth_cnt_r    <= 5'd0;
      wd_r         <= {WD_W{1'b0}};
      sl_cen_r     <= 1'b1;
      sl_a_r       <= {SL_AW{1'b0}};
      eng_rst_r    <= 1'b0;
      eng_sprite_r <= 1'b0;
      eng_type_r   <= 2'b00;
      eng_x_r      <= 6'd0;
      eng_y_r      <= 6'd0;
      eng_start_r  <= 1'b0;
      busy_r       <= 1'b0;
      frame_done_r <= 1'b0;
      err_r        <= 1'b0;
    end else begin
      eng_rst_r    <= 1'b0;
      eng_sprite_r <= 1'b0;
      eng_start_r  <= 1'b0;
      frame_done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.go) begin
            if (len_ok_s) begin
              err_r      <= 1'b0;
              man_cnt_r  <= 5'd0;
              oth_cnt_r  <= 5'd0;
              len_r      <= bus.scn_cnt;
              erst_cnt_r <= 1'b0;
              eng_rst_r  <= 1'b1;
              busy_r     <= 1'b1;
              state_r    <= ERST;
            end else begin
              err_r <= 1'b1;
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
        ERST: begin
          if (!erst_cnt_r) begin
            erst_cnt_r <= 1'b1;
            eng_rst_r  <= 1'b1;
          end else begin
            c_r      <= {SL_AW{1'b0}};
            sl_cen_r <= 1'b0;
            sl_a_r   <= {SL_AW{1'b0}};
            state_r  <= STREAM;
          end
        end
        STREAM: begin
          c_r <= c_next_s;
          if (c_next_s < len_r) begin
            sl_cen_r <= 1'b0;
            sl_a_r   <= c_next_s;
          end else begin
            sl_cen_r <= 1'b1;
          end
          if (strobe_s) begin
            eng_sprite_r <= 1'b1;
            eng_type_r   <= q_type_s;
            eng_y_r      <= bus.SL_Q[11:6];
            eng_x_r      <= bus.SL_Q[5:0];
            if (q_type_s == 2'b00) begin
              man_cnt_r <= sat_inc5(man_cnt_r);
            end else begin
              oth_cnt_r <= sat_inc5(oth_cnt_r);
            end
          end
          // The last strobe is on the outputs during c == len+1
          if (c_r == (len_r + SL_AW'(1'b1))) begin
            state_r <= CHECK;
          end
        end
        CHECK: begin
          if (scene_bad_s) begin
            err_r   <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else begin
            eng_start_r <= 1'b1;
            state_r     <= START;
          end
        end
        START: begin
          wd_r    <= {WD_W{1'b0}};
          state_r <= RUN;
        end
        RUN: begin
          // done is tested first so it wins over a same-cycle timeout
          if (bus.eng_done) begin
            frame_done_r <= 1'b1;
            state_r      <= FIN;
          end else if (wd_r == WD_LAST) begin
            err_r     <= 1'b1;
            eng_rst_r <= 1'b1;
            busy_r    <= 1'b0;
            state_r   <= IDLE;
          end else begin
            wd_r <= wd_r + WD_W'(1'b1);
          end
        end
        FIN: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          sl_cen_r <= 1'b1;
          busy_r   <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sgde_scene_sequencer.sv
// Randomized bench for sgde_scene_sequencer: a timeline model built from the frame rules
// predicts reset pulses, ROM addresses, strobes, start, done and error for each frame.
module tb_sgde_scene_sequencer;

  localparam int          TIMEOUT  = 64;
  localparam logic [25:0] RST_OUTS = {1'b1, 25'd0};

  logic        clk;
  logic        reset;
  int          tests;
  int          fails;
  logic [13:0] rom   [0:31];
  logic [13:0] scene [0:31];
  logic [13:0] rom_q;

  sgde_scene_sequencer_if #(.SL_AW(5)) bus ();

  sgde_scene_sequencer #(
    .SL_AW   (5),
    .MAX_OTH (19),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // synchronous scene ROM: data one cycle after the address, only while enabled
  always_ff @(posedge clk) begin
    if (!bus.SL_CEN) rom_q <= rom[bus.SL_A];
  end
  assign bus.SL_Q = rom_q;

  function automatic logic [25:0] outs();
    return {bus.SL_CEN, bus.SL_A, bus.eng_rst, bus.eng_sprite, bus.eng_type, bus.eng_X,
            bus.eng_Y, bus.eng_start, bus.busy, bus.frame_done, bus.err};
  endfunction

  task automatic make_scene(input int len, input int men);
    int p;
    for (int i = 0; i < len; i++)
      scene[i] = {2'($urandom_range(3, 1)), 6'($urandom_range(63, 0)), 6'($urandom_range(63, 0))};
    if (men >= 1) begin
      p = $urandom_range(len - 1, 0);
      scene[p][13:12] = 2'b00;
      if (men >= 2 && len >= 2) scene[(p + 1) % len][13:12] = 2'b00;
    end
  endtask

  // One frame from go to return to IDLE; done_delay <= 0 means eng_done never rises
  task automatic run_frame(input int len, input int done_delay, input bit hold_go, input string name);
    int man_n, oth_n, cyc, start_cyc, fd_cyc, end_cyc, n_start, n_fd, exp_start, exp_end;
    bit exp_err, exp_to, exp_fd;
    int rst_q[$];
    int exp_rst[$];
    int addr_q[$];
    int addr_cyc[$];
    int str_cyc[$];
    logic [13:0] str_q[$];

    man_n = 0;
    oth_n = 0;
    for (int i = 0; i < len; i++) begin
      rom[i] = scene[i];
      if (scene[i][13:12] == 2'b00) man_n++;
      else oth_n++;
    end
    // cycle 1,2 = engine reset, 3.. = addresses, 5.. = strobes, then check, then start
    exp_err   = (man_n != 1) || (oth_n > 19);
    exp_to    = !exp_err && (done_delay <= 0 || done_delay > TIMEOUT);
    exp_fd    = !exp_err && !exp_to;
    exp_start = len + 6;
    exp_end   = exp_err ? len + 6 : (exp_to ? exp_start + TIMEOUT + 1 : exp_start + done_delay + 2);
    exp_rst.push_back(1);
    exp_rst.push_back(2);
    if (exp_to) exp_rst.push_back(exp_end);

    @(negedge clk);
    bus.scn_cnt = 5'(len);
    bus.go      = 1'b1;
    @(negedge clk);
    if (!hold_go) bus.go = 1'b0;
    tests++;
    if (bus.busy !== 1'b1 || bus.err !== 1'b0) begin
      fails++;
      $display("FAIL %s.accept: busy=%b err=%b, want busy=1 err=0", name, bus.busy, bus.err);
    end

    cyc = 1; start_cyc = -1; fd_cyc = -1; end_cyc = -1; n_start = 0; n_fd = 0;
    while (end_cyc < 0 && cyc < 400) begin
      if (bus.eng_rst === 1'b1) rst_q.push_back(cyc);
      if (bus.SL_CEN === 1'b0) begin
        addr_q.push_back(int'(bus.SL_A));
        addr_cyc.push_back(cyc);
      end
      if (bus.eng_sprite === 1'b1) begin
        str_q.push_back({bus.eng_type, bus.eng_Y, bus.eng_X});
        str_cyc.push_back(cyc);
      end
      if (bus.eng_start === 1'b1) begin n_start++; start_cyc = cyc; end
      if (bus.frame_done === 1'b1) begin n_fd++; fd_cyc = cyc; end
      if (bus.busy !== 1'b1) begin
        end_cyc = cyc;
      end else begin
        if (start_cyc > 0 && done_delay > 0 && cyc == start_cyc + done_delay) bus.eng_done = 1'b1;
        @(negedge clk);
        cyc++;
      end
    end
    bus.eng_done = 1'b0;

    tests++;
    if (end_cyc != exp_end) begin
      fails++;
      $display("FAIL %s.idle_cycle: got %0d want %0d", name, end_cyc, exp_end);
    end
    tests++;
    if (bus.err !== (exp_err || exp_to)) begin
      fails++;
      $display("FAIL %s.err: got %b want %b", name, bus.err, exp_err || exp_to);
    end
    tests++;
    if (rst_q.size() != exp_rst.size()) begin
      fails++;
      $display("FAIL %s.eng_rst_count: got %0d want %0d", name, rst_q.size(), exp_rst.size());
    end
    for (int k = 0; k < rst_q.size() && k < exp_rst.size(); k++) begin
      tests++;
      if (rst_q[k] != exp_rst[k]) begin
        fails++;
        $display("FAIL %s.eng_rst[%0d]: got cycle %0d want %0d", name, k, rst_q[k], exp_rst[k]);
      end
    end
    tests++;
    if (addr_q.size() != len) begin
      fails++;
      $display("FAIL %s.addr_count: got %0d want %0d", name, addr_q.size(), len);
    end
    for (int k = 0; k < addr_q.size() && k < len; k++) begin
      tests++;
      if (addr_q[k] != k || addr_cyc[k] != 3 + k) begin
        fails++;
        $display("FAIL %s.addr[%0d]: got %0d@%0d want %0d@%0d", name, k, addr_q[k], addr_cyc[k], k, 3 + k);
      end
    end
    tests++;
    if (str_q.size() != len) begin
      fails++;
      $display("FAIL %s.strobe_count: got %0d want %0d", name, str_q.size(), len);
    end
    for (int k = 0; k < str_q.size() && k < len; k++) begin
      tests++;
      if (str_q[k] !== scene[k] || str_cyc[k] != 5 + k) begin
        fails++;
        $display("FAIL %s.strobe[%0d]: got %h@%0d want %h@%0d", name, k, str_q[k], str_cyc[k], scene[k], 5 + k);
      end
    end
    tests++;
    if ({bus.eng_type, bus.eng_Y, bus.eng_X} !== scene[len - 1]) begin
      fails++;
      $display("FAIL %s.desc_hold: got %h want %h", name, {bus.eng_type, bus.eng_Y, bus.eng_X}, scene[len - 1]);
    end
    tests++;
    if (n_start != (exp_err ? 0 : 1) || (!exp_err && start_cyc != exp_start)) begin
      fails++;
      $display("FAIL %s.start: got %0d pulses @%0d want %0d @%0d", name, n_start, start_cyc, exp_err ? 0 : 1, exp_start);
    end
    tests++;
    if (n_fd != (exp_fd ? 1 : 0) || (exp_fd && fd_cyc != exp_start + done_delay + 1)) begin
      fails++;
      $display("FAIL %s.frame_done: got %0d pulses @%0d want %0d @%0d", name, n_fd, fd_cyc, exp_fd ? 1 : 0,
               exp_start + done_delay + 1);
    end

    @(negedge clk);
    if (!hold_go) begin
      tests++;
      if ({bus.eng_rst, bus.frame_done, bus.busy, bus.eng_start, bus.eng_sprite, bus.err} !==
          {5'b00000, exp_err || exp_to}) begin
        fails++;
        $display("FAIL %s.settle: got rst=%b fd=%b busy=%b start=%b spr=%b err=%b", name, bus.eng_rst,
                 bus.frame_done, bus.busy, bus.eng_start, bus.eng_sprite, bus.err);
      end
    end else begin
      tests++;
      if (bus.busy !== 1'b1 || bus.eng_rst !== 1'b1) begin
        fails++;
        $display("FAIL %s.retrigger: got busy=%b eng_rst=%b want 1 1", name, bus.busy, bus.eng_rst);
      end
      bus.go       = 1'b0;
      bus.eng_done = 1'b1;
      for (int i = 0; i < 200 && bus.busy === 1'b1; i++) @(negedge clk);
      bus.eng_done = 1'b0;
      tests++;
      if (bus.busy !== 1'b0) begin
        fails++;
        $display("FAIL %s.drain: busy got %b want 0", name, bus.busy);
      end
    end
  endtask

  task automatic test_reset();
    reset        = 1'b0;
    bus.go       = 1'b0;
    bus.scn_cnt  = 5'd0;
    bus.eng_done = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if (outs() !== RST_OUTS) begin
      fails++;
      $display("FAIL reset.outs: got %h want %h", outs(), RST_OUTS);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (outs() !== RST_OUTS) begin
      fails++;
      $display("FAIL reset.idle_outs: got %h want %h", outs(), RST_OUTS);
    end
  endtask

  task automatic test_basic();
    scene[0] = {2'b00, 6'd10, 6'd10};
    scene[1] = {2'b01, 6'($urandom_range(63, 0)), 6'($urandom_range(63, 0))};
    scene[2] = {2'b11, 6'($urandom_range(63, 0)), 6'($urandom_range(63, 0))};
    scene[3] = {2'b11, 6'($urandom_range(63, 0)), 6'($urandom_range(63, 0))};
    run_frame(4, 50, 1'b0, "basic");
  endtask

  task automatic test_bad_len();
    int lens[3];
    lens[0] = 0;
    lens[1] = 21;
    lens[2] = $urandom_range(31, 22);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      bus.scn_cnt = 5'(lens[j]);
      bus.go      = 1'b1;
      @(negedge clk);
      bus.go = 1'b0;
      tests++;
      if ({bus.err, bus.busy, bus.SL_CEN, bus.eng_rst} !== 4'b1010) begin
        fails++;
        $display("FAIL bad_len%0d.reject: got err,busy,cen,rst=%b want 1010", lens[j],
                 {bus.err, bus.busy, bus.SL_CEN, bus.eng_rst});
      end
      repeat (3) @(negedge clk);
      tests++;
      if ({bus.err, bus.busy, bus.SL_CEN, bus.eng_rst} !== 4'b1010) begin
        fails++;
        $display("FAIL bad_len%0d.stay_idle: got err,busy,cen,rst=%b want 1010", lens[j],
                 {bus.err, bus.busy, bus.SL_CEN, bus.eng_rst});
      end
    end
  endtask

  task automatic test_no_man();
    scene[0] = {2'b10, 6'd3, 6'd4};
    scene[1] = {2'b10, 6'd5, 6'd6};
    run_frame(2, 50, 1'b0, "no_man");
  endtask

  task automatic test_timeout();
    make_scene(5, 1);
    run_frame(5, 0, 1'b0, "timeout");
  endtask

  task automatic test_done_at_limit();
    make_scene(3, 1);
    run_frame(3, TIMEOUT, 1'b0, "done_at_limit");
  endtask

  task automatic test_full_length();
    make_scene(20, 1);
    run_frame(20, 7, 1'b0, "full_len");
  endtask

  task automatic test_random();
    int len, men;
    for (int it = 0; it < 8; it++) begin
      len = $urandom_range(20, 1);
      men = ($urandom_range(3, 0) == 0) ? (($urandom_range(1, 0) == 0) ? 0 : 2) : 1;
      make_scene(len, men);
      run_frame(len, $urandom_range(60, 1), 1'b0, "random");
    end
  endtask

  task automatic test_back_to_back();
    make_scene(2, 1);
    run_frame(2, 5, 1'b1, "back_to_back");
  endtask

  task automatic test_reset_mid();
    make_scene(10, 1);
    for (int i = 0; i < 10; i++) rom[i] = scene[i];
    @(negedge clk);
    bus.scn_cnt = 5'd10;
    bus.go      = 1'b1;
    @(negedge clk);
    bus.go = 1'b0;
    repeat (6) @(negedge clk);
    tests++;
    if (bus.eng_sprite !== 1'b1 || bus.SL_CEN !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid.streaming: got spr=%b cen=%b want 1 0", bus.eng_sprite, bus.SL_CEN);
    end
    #2 reset = 1'b0;
    #1;
    tests++;
    if (outs() !== RST_OUTS) begin
      fails++;
      $display("FAIL reset_mid.async: got %h want %h", outs(), RST_OUTS);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if (outs() !== RST_OUTS) begin
      fails++;
      $display("FAIL reset_mid.idle: got %h want %h", outs(), RST_OUTS);
    end
    run_frame(10, 20, 1'b0, "after_reset");
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_basic();
    test_bad_len();
    test_no_man();
    test_timeout();
    test_done_at_limit();
    test_full_length();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit: simulation still running at %0t", $time);
    $fatal(1);
  end

endmodule
